// File: rtl/lms_train_ctrl.sv
// lms_train_ctrl: sequencing controller for the LMS adaptive filter.
// Moves (x, d) pairs into the filter one at a time, runs a flush and a bounded
// training phase, freezes the weights on convergence or timeout, and returns
// each y/err result on a valid/ready stream.
//
// Ports:
//   clk, reset (async, active-low)  start, abort  control
//   s_valid/s_ready/s_x/s_d         sample input stream
//   f_rst_n/f_ce/f_adapt/f_x/f_d    filter control and sample
//   f_y/f_err                       filter output and error
//   m_valid/m_ready/m_y/m_err       result output stream
//   state, converged, train_cnt     status
module lms_train_ctrl #(
    parameter int DATA_WIDTH   = 12,
    parameter int FILTER_ORDER = 5,
    parameter int CNT_WIDTH    = 16,
    parameter int TRAIN_LEN    = 1024,
    parameter int CONV_THRESH  = 8,
    parameter int CONV_RUN     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_x,
    input  logic [DATA_WIDTH-1:0] s_d,
    output logic                  f_rst_n,
    output logic                  f_ce,
    output logic                  f_adapt,
    output logic [DATA_WIDTH-1:0] f_x,
    output logic [DATA_WIDTH-1:0] f_d,
    input  logic [DATA_WIDTH-1:0] f_y,
    input  logic [DATA_WIDTH-1:0] f_err,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_y,
    output logic [DATA_WIDTH-1:0] m_err,
    output logic [1:0]            state,
    output logic                  converged,
    output logic [CNT_WIDTH-1:0]  train_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        TRAIN = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam int FW = $clog2(FILTER_ORDER + 1);
    localparam int RW = $clog2(CONV_RUN + 1);

    localparam logic [FW-1:0]         FLUSH_LAST = FW'(FILTER_ORDER - 1);
    localparam logic [RW-1:0]         RUN_MAX    = RW'(CONV_RUN);
    localparam logic [CNT_WIDTH-1:0]  TLEN       = CNT_WIDTH'(TRAIN_LEN);
    localparam logic [DATA_WIDTH:0]   THRESH     = (DATA_WIDTH + 1)'(CONV_THRESH);

    state_t st_q, st_d;

    logic [FW-1:0]       flush_cnt;
    logic [RW-1:0]       run_q;
    logic [RW-1:0]       run_nxt;
    logic                cap_q;
    logic                accept;
    logic                drop;
    logic                enter_flush;
    logic                train_cap;
    logic                hit_conv;
    logic                hit_len;
    logic [DATA_WIDTH:0] err_ext;
    logic [DATA_WIDTH:0] err_abs;

    // One extra bit so the most negative error has a representable magnitude.
    assign err_ext = {f_err[DATA_WIDTH-1], f_err};
    assign err_abs = err_ext[DATA_WIDTH] ? -err_ext : err_ext;

    assign run_nxt  = (err_abs <= THRESH) ? run_q + 1'b1 : '0;
    assign hit_conv = (run_nxt == RUN_MAX);
    assign hit_len  = (train_cnt == TLEN);

    // Abort, or a retrain request from RUN, discards whatever is in flight.
    assign drop      = abort || (st_q == RUN && start);
    assign train_cap = cap_q && (st_q == TRAIN);

    assign accept      = s_valid && s_ready;
    assign enter_flush = (st_d == FLUSH) && (st_q != FLUSH);

    always_comb begin
        st_d = st_q;
        if (abort) begin
            st_d = IDLE;
        end else begin
            unique case (st_q)
                IDLE:  if (start) st_d = FLUSH;
                FLUSH: if (flush_cnt == FLUSH_LAST) st_d = TRAIN;
                TRAIN: if (train_cap && (hit_conv || hit_len)) st_d = RUN;
                RUN:   if (start) st_d = FLUSH;
            endcase
        end
    end

    always_comb begin
        f_rst_n = 1'b0;
        f_adapt = 1'b0;
        s_ready = 1'b0;
        if (st_q == TRAIN || st_q == RUN) begin
            f_rst_n = 1'b1;
            s_ready = !f_ce && !cap_q && !m_valid && !drop;
        end
        if (st_q == TRAIN) begin
            f_adapt = 1'b1;
        end
    end

    assign state = st_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q      <= IDLE;
            flush_cnt <= '0;
            run_q     <= '0;
            cap_q     <= 1'b0;
            f_ce      <= 1'b0;
            f_x       <= '0;
            f_d       <= '0;
            m_valid   <= 1'b0;
            m_y       <= '0;
            m_err     <= '0;
            converged <= 1'b0;
            train_cnt <= '0;
        end else begin
            st_q <= st_d;

            if (st_q == FLUSH) begin
                flush_cnt <= flush_cnt + 1'b1;
            end else begin
                flush_cnt <= '0;
            end

            if (accept) begin
                f_x <= s_x;
                f_d <= s_d;
            end
            f_ce  <= accept;
            cap_q <= f_ce && !drop;

            if (drop) begin
                m_valid <= 1'b0;
            end else if (cap_q) begin
                m_valid <= 1'b1;
                m_y     <= f_y;
                m_err   <= f_err;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            if (enter_flush) begin
                train_cnt <= '0;
            end else if (accept && st_q == TRAIN && train_cnt != '1) begin
                train_cnt <= train_cnt + 1'b1;
            end

            if (enter_flush) begin
                run_q <= '0;
            end else if (train_cap && !abort) begin
                run_q <= run_nxt;
            end

            if (abort || enter_flush) begin
                converged <= 1'b0;
            end else if (train_cap && hit_conv) begin
                converged <= 1'b1;
            end
        end
    end

endmodule
